// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: forwarding select type, control modes and stage indices for the pipeline controller
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {
    fwd_none = 2'b00,
    fwd_mem  = 2'b01,
    fwd_wb   = 2'b10
  } fwdmux_sel_t;
  typedef enum logic [2:0] {
    mode_run,
    mode_istall,
    mode_lu,
    mode_redirect,
    mode_dstall
  } ctrl_mode_t;
  localparam int ID_STAGE  = 1;
  localparam int EX_STAGE  = 2;
  localparam int MEM_STAGE = 3;
  function automatic fwdmux_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
    return mem_hit ? fwd_mem : wb_hit ? fwd_wb : fwd_none;
  endfunction
endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] out
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) out <= '0;
    else if (inc && !(&out)) out <= out + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stage valids, load enables, stall/flush handling and EX forwarding selects
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_STAGES     = 5,
  parameter int REDIRECT_STAGE = 3,
  parameter int REG_W          = 5,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_W-1:0]      id_rs1,
  input  logic [REG_W-1:0]      id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_W-1:0]      ex_rs1,
  input  logic [REG_W-1:0]      ex_rs2,
  input  logic [REG_W-1:0]      ex_rd,
  input  logic                  ex_load_regfile,
  input  logic                  ex_mem_read,
  input  logic [REG_W-1:0]      mem_rd,
  input  logic [REG_W-1:0]      wb_rd,
  input  logic                  mem_load_regfile,
  input  logic                  wb_load_regfile,
  input  logic                  inst_read,
  input  logic                  inst_resp,
  input  logic                  data_req,
  input  logic                  data_resp,
  input  logic                  redirect,
  output logic [NUM_STAGES-1:0] stage_load,
  output logic [NUM_STAGES-1:0] stage_valid,
  output fwdmux_sel_t           fwd_a_sel,
  output fwdmux_sel_t           fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);
  logic [NUM_STAGES-1:1] valid_q, valid_d;
  logic discard_q, discard_d;
  logic d_stall, i_stall, lu_stall, rd_take, id_hit;
  logic mem_fwd_ok, wb_fwd_ok;
  ctrl_mode_t mode;
  assign stage_valid = {valid_q, 1'b1};
  assign id_hit = (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
  assign d_stall = stage_valid[MEM_STAGE] && data_req && !data_resp;
  assign i_stall = inst_read && !inst_resp;
  assign lu_stall = stage_valid[ID_STAGE] && stage_valid[EX_STAGE] && ex_mem_read &&
                    ex_load_regfile && ex_rd != '0 && id_hit;
  assign rd_take = redirect && stage_valid[REDIRECT_STAGE];
  assign mode = d_stall  ? mode_dstall :
                rd_take  ? mode_redirect :
                lu_stall ? mode_lu :
                i_stall  ? mode_istall : mode_run;
  assign stage_load = !rst                 ? '1 :
                      mode == mode_dstall  ? '0 :
                      mode == mode_lu      ? {{(NUM_STAGES-2){1'b1}}, 2'b00} :
                      mode == mode_istall  ? {{(NUM_STAGES-1){1'b1}}, 1'b0} : '1;
  // Register 1 takes the fetched word only when the PC advances and no squash is pending
  always_comb begin
    valid_d = valid_q;
    discard_d = discard_q;
    if (mode != mode_dstall) begin
      for (int k = 2; k < NUM_STAGES; k++) valid_d[k] = stage_valid[k-1];
      if (mode == mode_redirect) begin
        for (int k = 1; k <= REDIRECT_STAGE; k++) valid_d[k] = 1'b0;
        discard_d = discard_q || i_stall;
      end else if (mode == mode_lu) begin
        valid_d[1] = valid_q[1];
        valid_d[2] = 1'b0;
      end else if (mode == mode_istall) begin
        valid_d[1] = 1'b0;
      end else begin
        valid_d[1] = !discard_q;
        discard_d = discard_q && !(inst_read && inst_resp);
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q <= '0;
      discard_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      discard_q <= discard_d;
    end
  assign mem_fwd_ok = stage_valid[MEM_STAGE] && mem_load_regfile && mem_rd != '0;
  assign wb_fwd_ok = stage_valid[NUM_STAGES-1] && wb_load_regfile && wb_rd != '0;
  assign fwd_a_sel = fwd_pick(mem_fwd_ok && mem_rd == ex_rs1, wb_fwd_ok && wb_rd == ex_rs1);
  assign fwd_b_sel = fwd_pick(mem_fwd_ok && mem_rd == ex_rs2, wb_fwd_ok && wb_rd == ex_rs2);
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(d_stall || lu_stall || i_stall),
    .out(stall_cycles)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(mode == mode_redirect),
    .out(flush_count)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a stage-level model
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;
  localparam int N = 5, R = 3, RW = 5, CW = 32;
  logic clk = 1'b0, rst = 1'b0;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_load_regfile, ex_mem_read;
  logic mem_load_regfile, wb_load_regfile, inst_read, inst_resp, data_req, data_resp, redirect;
  logic [N-1:0] stage_load, stage_valid;
  fwdmux_sel_t fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cycles, flush_count;
  int checks = 0, failures = 0;
  bit mv[N];
  bit nv[N];
  bit md, nd;
  logic [CW-1:0] ms, mf, ns, nf, base_s, base_f;

  pipeline_ctrl #(.NUM_STAGES(N), .REDIRECT_STAGE(R), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_load_regfile(ex_load_regfile), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_load_regfile(mem_load_regfile), .wb_load_regfile(wb_load_regfile),
    .inst_read(inst_read), .inst_resp(inst_resp),
    .data_req(data_req), .data_resp(data_resp), .redirect(redirect),
    .stage_load(stage_load), .stage_valid(stage_valid),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  function automatic logic [N-1:0] packv();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = mv[k];
    return r;
  endfunction

  function automatic logic [1:0] fsel(input logic [RW-1:0] src);
    if (mv[3] && mem_load_regfile && mem_rd != '0 && mem_rd == src) return 2'd1;
    if (mv[N-1] && wb_load_regfile && wb_rd != '0 && wb_rd == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic set_idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_load_regfile, ex_mem_read} = '0;
    {mem_load_regfile, wb_load_regfile, data_req, data_resp, redirect} = '0;
    inst_read = 1'b1;
    inst_resp = 1'b1;
  endtask

  // Compare DUT against the model for the current inputs, then compute the model's next state
  task automatic settle();
    bit ds, is, lu, rt, fetch_ok;
    logic [N-1:0] ld;
    #1;
    if (!rst) begin
      for (int k = 0; k < N; k++) mv[k] = (k == 0);
      md = 1'b0;
      ms = '0;
      mf = '0;
    end
    ds = mv[3] && data_req && !data_resp;
    is = inst_read && !inst_resp;
    lu = mv[1] && mv[2] && ex_mem_read && ex_load_regfile && ex_rd != '0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    rt = redirect && mv[R];
    ld = '1;
    if (rst) begin
      if (ds) ld = '0;
      else if (!rt && lu) ld[1:0] = 2'b00;
      else if (!rt && is) ld[0] = 1'b0;
    end
    chk("stage_valid", stage_valid, packv());
    chk("stage_load", stage_load, ld);
    chk("fwd_a_sel", fwd_a_sel, fsel(ex_rs1));
    chk("fwd_b_sel", fwd_b_sel, fsel(ex_rs2));
    chk("stall_cycles", stall_cycles, ms);
    chk("flush_count", flush_count, mf);
    fetch_ok = ld[0] && !md;
    nv[0] = 1'b1;
    for (int k = 1; k < N; k++)
      nv[k] = !ld[k] ? mv[k] : (k == 1) ? fetch_ok : (lu && !rt && k == 2) ? 1'b0 : mv[k-1];
    if (rt && !ds) for (int k = 1; k <= R; k++) nv[k] = 1'b0;
    nd = md;
    if (!ds) begin
      if (rt) nd = md || is;
      else if (!lu && !is && inst_read && inst_resp) nd = 1'b0;
    end
    ns = (ds || lu || is) ? sat(ms) : ms;
    nf = (rt && !ds) ? sat(mf) : mf;
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      mv = nv;
      md = nd;
      ms = ns;
      mf = nf;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      set_idle();
      settle();
      adv();
    end
  endtask

  initial begin
    logic [N-1:0] exp_fill [5];
    exp_fill[0] = 5'b00001; exp_fill[1] = 5'b00011; exp_fill[2] = 5'b00111;
    exp_fill[3] = 5'b01111; exp_fill[4] = 5'b11111;
    set_idle();
    rst = 1'b0;
    @(negedge clk);
    repeat (3) begin
      settle();
      chk("rst_load", stage_load, 5'b11111);
      chk("rst_valid", stage_valid, 5'b00001);
      adv();
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("fill_valid", stage_valid, exp_fill[i]);
      if (i < 4) adv();
    end
    chk("fill_stall", stall_cycles, 0);
    chk("fill_flush", flush_count, 0);
    adv();
    // load-use: add x3,x1,x2 in ID behind lw x1 in EX
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    ex_rd = 5'd1; ex_mem_read = 1'b1; ex_load_regfile = 1'b1;
    settle();
    chk("lu_load", stage_load, 5'b11100);
    adv();
    ex_rd = '0; ex_mem_read = 1'b0; ex_load_regfile = 1'b0;
    settle();
    chk("lu_bubble", stage_valid, 5'b11011);
    adv();
    set_idle();
    ex_rs1 = 5'd1; ex_rs2 = 5'd2; wb_rd = 5'd1; wb_load_regfile = 1'b1;
    settle();
    chk("lu_valid", stage_valid, 5'b10111);
    chk("lu_fwd_wb", fwd_a_sel, 2'd2);
    chk("lu_stall_cnt", stall_cycles, 1);
    adv();
    idle(4);
    mem_rd = 5'd5; wb_rd = 5'd5; ex_rs2 = 5'd5; mem_load_regfile = 1'b1; wb_load_regfile = 1'b1;
    settle();
    chk("fwd_mem_wins", fwd_b_sel, 2'd1);
    mem_rd = '0; wb_rd = '0; ex_rs2 = '0;
    settle();
    chk("fwd_x0_none", fwd_b_sel, 2'd0);
    adv();
    set_idle();
    redirect = 1'b1;
    settle();
    chk("rd_load", stage_load, 5'b11111);
    adv();
    set_idle();
    settle();
    chk("rd_valid", stage_valid, 5'b10001);
    chk("rd_flush", flush_count, 1);
    adv();
    idle(4);
    // redirect while the fetch is outstanding arms the squash of the next response
    inst_resp = 1'b0; redirect = 1'b1;
    settle();
    adv();
    redirect = 1'b0;
    settle();
    chk("disc_valid", stage_valid, 5'b10001);
    adv();
    inst_resp = 1'b1;
    settle();
    adv();
    settle();
    chk("disc_squash", stage_valid[1], 1'b0);
    adv();
    settle();
    chk("disc_accept", stage_valid, 5'b00011);
    adv();
    idle(4);
    base_s = ms; base_f = mf;
    data_req = 1'b1; data_resp = 1'b0; redirect = 1'b1;
    id_rs1 = 5'd1; id_uses_rs1 = 1'b1; ex_rd = 5'd1; ex_mem_read = 1'b1; ex_load_regfile = 1'b1;
    repeat (4) begin
      settle();
      chk("dwait_load", stage_load, 5'b00000);
      adv();
    end
    set_idle();
    settle();
    chk("dwait_valid", stage_valid, 5'b11111);
    chk("dwait_stall", stall_cycles, base_s + 4);
    chk("dwait_flush", flush_count, base_f);
    adv();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 249) != 0);
      id_rs1 = RW'($urandom_range(0, 3)); id_rs2 = RW'($urandom_range(0, 3));
      ex_rs1 = RW'($urandom_range(0, 3)); ex_rs2 = RW'($urandom_range(0, 3));
      ex_rd = RW'($urandom_range(0, 3)); mem_rd = RW'($urandom_range(0, 3));
      wb_rd = RW'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      ex_load_regfile = ($urandom_range(0, 3) != 0); ex_mem_read = ($urandom_range(0, 2) == 0);
      mem_load_regfile = 1'($urandom); wb_load_regfile = 1'($urandom);
      inst_read = ($urandom_range(0, 9) != 0); inst_resp = ($urandom_range(0, 3) != 0);
      data_req = ($urandom_range(0, 2) == 0); data_resp = 1'($urandom);
      redirect = ($urandom_range(0, 5) == 0);
      settle();
      adv();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
